// File: rtl/fft_frame_loader_if.sv
// Frame loader port bundle: shifter/strobe inputs, framed output handshake, status.
// master = the environment around the loader, slave = the loader itself.
interface fft_frame_loader_if #(
    parameter int NUM_SAMPLES = 48,
    parameter int DATA_W      = 16,
    parameter int CNT_W       = 6,
    parameter int FRM_CNT_W   = 16
);
    logic                                   sample_strobe;
    logic                                   frame_sync;
    logic [NUM_SAMPLES-1:0][DATA_W-1:0]     par_in;
    logic [NUM_SAMPLES-1:0][DATA_W-1:0]     frame_data;
    logic                                   frame_valid;
    logic                                   frame_ready;
    logic                                   overflow;
    logic                                   overflow_clr;
    logic [CNT_W-1:0]                       fill_level;
    logic [FRM_CNT_W-1:0]                   frame_cnt;

    modport master (
        output sample_strobe, frame_sync, par_in, frame_ready, overflow_clr,
        input  frame_data, frame_valid, overflow, fill_level, frame_cnt
    );

    modport slave (
        input  sample_strobe, frame_sync, par_in, frame_ready, overflow_clr,
        output frame_data, frame_valid, overflow, fill_level, frame_cnt
    );
endinterface

// File: rtl/fft_frame_loader.sv
// Snapshots the sample shifter every NUM_SAMPLES strobes and offers the frame to the FFT core.
// Latency: frame_valid rises 1 cycle after the edge that samples the last strobe of a frame.
// Backpressure: one-frame holding register; a frame completing while the held one is unaccepted is dropped and flags overflow.
module fft_frame_loader #(
    parameter int NUM_SAMPLES = 48,
    parameter int DATA_W      = 16,
    parameter int CNT_W       = 6,
    parameter int FRM_CNT_W   = 16
) (
    input  logic              clk,
    input  logic              n_rst,
    fft_frame_loader_if.slave bus
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t                             state, state_nxt;
    logic                               capture_pend;
    logic [CNT_W-1:0]                   fill_q;
    logic [NUM_SAMPLES-1:0][DATA_W-1:0] frame_q;
    logic                               overflow_q;
    logic [FRM_CNT_W-1:0]               cnt_q;
    logic                               load;
    logic                               drop;

    // capture_pend is a registered flag so the shifter has absorbed the last sample before we snapshot it.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            fill_q       <= '0;
            capture_pend <= 1'b0;
        end else if (bus.frame_sync) begin
            fill_q       <= '0;
            capture_pend <= 1'b0;
        end else if (bus.sample_strobe) begin
            if (fill_q == CNT_W'(NUM_SAMPLES - 1)) begin
                fill_q       <= '0;
                capture_pend <= 1'b1;
            end else begin
                fill_q       <= fill_q + CNT_W'(1);
                capture_pend <= 1'b0;
            end
        end else begin
            capture_pend <= 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        drop      = 1'b0;
        case (state)
            EMPTY: begin
                if (capture_pend) begin
                    load      = 1'b1;
                    state_nxt = FULL;
                end
            end
            FULL: begin
                // Accept and reload in the same cycle keeps the core fed without a bubble.
                if (capture_pend) begin
                    if (bus.frame_ready) load = 1'b1;
                    else                 drop = 1'b1;
                end else if (bus.frame_ready) begin
                    state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= EMPTY;
            frame_q    <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load) begin
                frame_q <= bus.par_in;
                cnt_q   <= cnt_q + FRM_CNT_W'(1);
            end
            if (drop)                  overflow_q <= 1'b1;
            else if (bus.overflow_clr) overflow_q <= 1'b0;
        end
    end

    assign bus.frame_data  = frame_q;
    assign bus.frame_valid = (state == FULL);
    assign bus.overflow    = overflow_q;
    assign bus.fill_level  = fill_q;
    assign bus.frame_cnt   = cnt_q;

endmodule

// File: tb/tb_fft_frame_loader.sv
// Bench for fft_frame_loader: directed scenarios plus random traffic against a sample-history model.
module tb_fft_frame_loader;
    localparam int N  = 48;
    localparam int DW = 16;
    localparam int CW = 6;
    localparam int FW = 16;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    fft_frame_loader_if #(.NUM_SAMPLES(N), .DATA_W(DW), .CNT_W(CW), .FRM_CNT_W(FW)) bus ();

    fft_frame_loader #(.NUM_SAMPLES(N), .DATA_W(DW), .CNT_W(CW), .FRM_CNT_W(FW)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    // Upstream shifter stand-in: index N-1 newest, index 0 oldest.
    logic [N-1:0][DW-1:0] shreg = '0;
    logic [DW-1:0]        smp   = '0;
    assign bus.par_in = shreg;

    int n_tests = 0;
    int n_fail  = 0;
    int vld_cycles = 0;

    // Reference model: history of samples since the last restart, frames cut every N samples.
    int                   hist[$];
    int                   m_strobes;
    bit                   m_pend, m_valid, m_ovf;
    logic [FW-1:0]        m_cnt;
    logic [N-1:0][DW-1:0] m_frame, m_cand, ref1;

    task automatic chk(input string tag, input logic [767:0] act, input logic [767:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic void m_reset();
        hist.delete();
        m_strobes = 0;
        m_pend    = 0;
        m_valid   = 0;
        m_ovf     = 0;
        m_cnt     = '0;
        m_frame   = '0;
        m_cand    = '0;
    endfunction

    task automatic step();
        bit cap, drp;
        @(posedge clk);
        #1;
        cap = m_pend;
        drp = 0;
        if (cap) begin
            if (!m_valid || bus.frame_ready) begin
                m_frame = m_cand;
                m_valid = 1;
                m_cnt   = m_cnt + 1'b1;
            end else begin
                drp = 1;
            end
        end else if (m_valid && bus.frame_ready) begin
            m_valid = 0;
        end
        if (drp)                   m_ovf = 1;
        else if (bus.overflow_clr) m_ovf = 0;
        m_pend = 0;
        if (bus.frame_sync) begin
            hist.delete();
            m_strobes = 0;
        end else if (bus.sample_strobe) begin
            hist.push_back(int'(smp));
            if (hist.size() > N) void'(hist.pop_front());
            m_strobes++;
            if (m_strobes % N == 0) begin
                m_pend = 1;
                for (int i = 0; i < N; i++) m_cand[i] = DW'(hist[i]);
            end
        end
        if (bus.sample_strobe) shreg = {smp, shreg[N-1:1]};
        if (bus.frame_valid) vld_cycles++;
        chk("fill", 768'(bus.fill_level), 768'(m_strobes % N));
        chk("valid", 768'(bus.frame_valid), 768'(m_valid));
        chk("ovf", 768'(bus.overflow), 768'(m_ovf));
        chk("cnt", 768'(bus.frame_cnt), 768'(m_cnt));
        if (m_valid) chk("data", bus.frame_data, m_frame);
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        bus.sample_strobe = 0;
        bus.frame_sync    = 0;
        bus.frame_ready   = 0;
        bus.overflow_clr  = 0;
        m_reset();
        #2;
        chk("rst_vld", 768'(bus.frame_valid), 768'(0));
        chk("rst_dat", bus.frame_data, 768'(0));
        chk("rst_ovf", 768'(bus.overflow), 768'(0));
        chk("rst_fill", 768'(bus.fill_level), 768'(0));
        chk("rst_cnt", 768'(bus.frame_cnt), 768'(0));
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    task automatic feed(input int n, input int gap, input int base);
        for (int i = 0; i < n; i++) begin
            bus.sample_strobe = 1;
            smp = DW'(base + i);
            step();
            bus.sample_strobe = 0;
            repeat (gap) step();
        end
    endtask

    task automatic accept();
        bus.frame_ready = 1;
        step();
        bus.frame_ready = 0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) ref1[i] = DW'(i + 1);
        do_reset();

        // Basic frame, consecutive strobes
        feed(N, 0, 1);
        chk("b_early", 768'(bus.frame_valid), 768'(0));
        step();
        chk("b_vld", 768'(bus.frame_valid), 768'(1));
        chk("b_d0", 768'(bus.frame_data[0]), 768'(1));
        chk("b_d47", 768'(bus.frame_data[N-1]), 768'(48));
        chk("b_cnt", 768'(bus.frame_cnt), 768'(1));
        chk("b_fill", 768'(bus.fill_level), 768'(0));
        accept();

        // Sparse strobes, one every 5th cycle
        feed(N, 4, 1);
        step();
        chk("s_dat", bus.frame_data, ref1);
        accept();

        // Ready held high, two frames back to back
        do_reset();
        bus.frame_ready = 1;
        vld_cycles = 0;
        feed(2 * N, 0, 1);
        step();
        chk("bb_d0", 768'(bus.frame_data[0]), 768'(49));
        step();
        chk("bb_vcyc", 768'(vld_cycles), 768'(2));
        chk("bb_cnt", 768'(bus.frame_cnt), 768'(2));
        chk("bb_ovf", 768'(bus.overflow), 768'(0));
        bus.frame_ready = 0;

        // Overflow with ready low
        do_reset();
        feed(2 * N, 0, 1);
        step();
        chk("o_ovf", 768'(bus.overflow), 768'(1));
        chk("o_d0", 768'(bus.frame_data[0]), 768'(1));
        chk("o_cnt", 768'(bus.frame_cnt), 768'(1));
        bus.overflow_clr = 1;
        step();
        bus.overflow_clr = 0;
        chk("o_clr", 768'(bus.overflow), 768'(0));
        feed(N, 0, 200);
        bus.overflow_clr = 1;
        step();
        bus.overflow_clr = 0;
        chk("o_setwin", 768'(bus.overflow), 768'(1));

        // Accept coinciding with capture of the next frame
        bus.overflow_clr = 1;
        step();
        bus.overflow_clr = 0;
        feed(N, 0, 300);
        bus.frame_ready = 1;
        step();
        bus.frame_ready = 0;
        chk("c_vld", 768'(bus.frame_valid), 768'(1));
        chk("c_d0", 768'(bus.frame_data[0]), 768'(300));
        chk("c_ovf", 768'(bus.overflow), 768'(0));
        chk("c_cnt", 768'(bus.frame_cnt), 768'(2));
        accept();

        // frame_sync discards a partial frame
        feed(20, 0, 500);
        bus.frame_sync = 1;
        step();
        bus.frame_sync = 0;
        chk("y_fill", 768'(bus.fill_level), 768'(0));
        feed(N - 1, 0, 600);
        step();
        chk("y_none", 768'(bus.frame_valid), 768'(0));
        feed(1, 0, 600 + N - 1);
        step();
        chk("y_vld", 768'(bus.frame_valid), 768'(1));
        chk("y_d0", 768'(bus.frame_data[0]), 768'(600));

        // Reset mid-frame with a frame held
        feed(30, 0, 800);
        do_reset();
        feed(N - 1, 0, 900);
        step();
        chk("r_none", 768'(bus.frame_valid), 768'(0));
        feed(1, 0, 900 + N - 1);
        step();
        chk("r_vld", 768'(bus.frame_valid), 768'(1));
        chk("r_d0", 768'(bus.frame_data[0]), 768'(900));
        accept();

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            bus.sample_strobe = ($urandom_range(3) != 0);
            bus.frame_ready   = ($urandom_range(2) == 0);
            bus.frame_sync    = ($urandom_range(199) == 0);
            bus.overflow_clr  = ($urandom_range(49) == 0);
            smp = DW'($urandom);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
